alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Execute-stage arithmetic unit that consumes the 4-bit `alu_operation` code produced by the ALU control decoder. It also consumes the two operands from the register file/immediate mux. Single-cycle operations (ADD, SUB, OR, LUI) return a registered result one cycle after issue. An optional iterative shift-add multiplier runs as a multi-cycle operation with a busy/done handshake, and the pipeline control uses that handshake to stall issue.

## Interface
- `DATA_WIDTH`, default 32: operand and result width; must be even and ≥ 8.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start_i` input 1: issue strobe; the operation is captured on an edge where `start_i`=1 and `busy_o`=0.
- `flush_i` input 1: abort the in-flight operation; no `done_o` follows.
- `alu_operation_i` input 4: operation code: 0011 ADD, 0100 SUB, 0010 OR, 0101 LUI, 0110 MULT; any other code is illegal.
- `a_data_i` input DATA_WIDTH: operand A.
- `b_data_i` input DATA_WIDTH: operand B (register or extended immediate).
- `alu_data_o` output DATA_WIDTH: result (low word for MULT).
- `hi_data_o` output DATA_WIDTH: high word of the MULT product; 0 for all other operations.
- `zero_o` output 1: `alu_data_o` == 0, registered with the result.
- `overflow_o` output 1: signed overflow, ADD/SUB only.
- `illegal_o` output 1: the last completed operation code was illegal.
- `busy_o` output 1: a multi-cycle operation is in flight.
- `done_o` output 1: one-cycle pulse; all result outputs are valid and updated this cycle.

## Operation
- States: IDLE, MUL.
- **IDLE, start_i=1, flush_i=0, single-cycle or illegal code:**
  - Compute and register all result outputs.
  - `done_o`=1 next cycle.
  - Remain in IDLE.
- **Single-cycle arithmetic:**
  - ADD: A+B mod 2^DATA_WIDTH; `overflow_o` = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: A−B; `overflow_o` = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - OR: A|B.
  - LUI: B[DATA_WIDTH/2−1:0] shifted left by DATA_WIDTH/2, low half zero.
  - Illegal code: `alu_data_o`=0, `hi_data_o`=0, `zero_o`=1, `illegal_o`=1.
- **IDLE, start_i=1, flush_i=0, MULT:**
  - Latch A as the multiplicand, B as the multiplier; clear the 2·DATA_WIDTH product; count=0.
  - Go to MUL; `busy_o`=1.
- **MUL, each edge:**
  - If multiplier bit 0 = 1, add the multiplicand (shifted by count) into the product.
  - Shift the multiplier right; count+1.
  - Product is unsigned, DATA_WIDTH × DATA_WIDTH → 2·DATA_WIDTH; `overflow_o`=0.
- **MUL, edge where count == DATA_WIDTH−1:**
  - Write the product: `hi_data_o` = upper half, `alu_data_o` = lower half, `zero_o` from the low word.
  - `illegal_o`=0; `done_o`=1 next cycle.
  - Go to IDLE.
- **start_i while busy_o=1:** ignored; no queuing.
- **flush_i=1:**
  - In MUL: go to IDLE next edge; result outputs keep their previous values; no `done_o`.
  - In IDLE with start_i=1: flush wins; nothing is issued.
- **Result outputs:** hold their values between `done_o` pulses.

## Timing
- Reset values: all outputs 0 except `zero_o`=1 (result reads 0); state IDLE; count 0.
- Reset has priority over flush, which has priority over start; reset mid-MULT aborts with no `done_o`.
- Single-cycle latency: issued on edge N → `done_o` high during the cycle after edge N.
- MULT latency:
  - Issued on edge N; MUL occupies edges N+1 … N+DATA_WIDTH.
  - `done_o` high after edge N+DATA_WIDTH.
  - `busy_o` high from after edge N until after edge N+DATA_WIDTH (deasserts as `done_o` asserts).
- Back-to-back: a new issue is accepted on the same edge that retires MULT only if `busy_o` was already 0. Otherwise the earliest next issue is the edge after `done_o`'s cycle begins, i.e. `start_i` is sampled while `busy_o`=0.
- Single-cycle ops may issue every cycle; `done_o` stays high continuously.

## Configuration
- `ALU_SEQ_MULT_EN` defined:
  - MUL state, counter and product datapath are compiled in.
  - 0110 behaves as MULT.
- `ALU_SEQ_MULT_EN` undefined:
  - No MUL state; `busy_o` is tied 0 and `hi_data_o` is tied 0.
  - 0110 is treated as an illegal code: 1-cycle latency, `illegal_o`=1.

## Test plan
- ADD A=0x7FFFFFFF, B=1 → after 1 cycle: `alu_data_o`=0x80000000, `overflow_o`=1, `zero_o`=0, single `done_o` pulse.
- SUB A=5, B=5, then LUI B=0x0000ABCD on the next cycle → `done_o` for 2 consecutive cycles: first result 0 with `zero_o`=1, then 0xABCD0000.
- MULT A=0xFFFFFFFF, B=0xFFFFFFFF (macro defined) → `busy_o` high for 32 cycles; `done_o` at cycle 33; `hi_data_o`=0xFFFFFFFE, `alu_data_o`=0x00000001; a `start_i` pulse at cycle 10 is ignored.
- MULT A=3, B=4 with `flush_i` at cycle 5 → no `done_o`; outputs keep prior values; `busy_o`=0 from cycle 6. Repeat with `reset` at cycle 5 → all outputs at reset values.
- Illegal code 1001, and 0110 with macro undefined → 1-cycle `done_o`, `illegal_o`=1, `alu_data_o`=0, `zero_o`=1, `busy_o` never asserted.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: registered single-cycle ADD/SUB/OR/LUI plus an optional
// iterative shift-add multiplier (compiled in when ALU_SEQ_MULT_EN is defined).
module alu_seq_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic [DATA_WIDTH-1:0] alu_data_o,
  output logic [DATA_WIDTH-1:0] hi_data_o,
  output logic                  zero_o,
  output logic                  overflow_o,
  output logic                  illegal_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int DW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_MULT = 4'b0110;

  logic [DW-1:0] r_alu;
  logic          r_zero, r_ovf, r_ill, r_done;
  logic [DW-1:0] w_res;
  logic          w_ovf, w_ill, w_is_mul, w_busy, w_accept;

  assign w_accept = start_i && !flush_i && !w_busy;

  always_comb begin
    w_res    = '0;
    w_ovf    = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (alu_operation_i)
      OP_ADD: begin
        w_res = a_data_i + b_data_i;
        w_ovf = (a_data_i[DW-1] == b_data_i[DW-1]) && (w_res[DW-1] != a_data_i[DW-1]);
      end
      OP_SUB: begin
        w_res = a_data_i - b_data_i;
        w_ovf = (a_data_i[DW-1] != b_data_i[DW-1]) && (w_res[DW-1] != a_data_i[DW-1]);
      end
      OP_OR:  w_res = a_data_i | b_data_i;
      OP_LUI: w_res = {b_data_i[HW-1:0], {HW{1'b0}}};
`ifdef ALU_SEQ_MULT_EN
      OP_MULT: w_is_mul = 1'b1;
`endif
      default: w_ill = 1'b1;  // result stays 0, so zero_o reads 1
    endcase
  end

`ifdef ALU_SEQ_MULT_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_t          r_state, w_state_nxt;
  logic [2*DW-1:0] r_prod, r_mcand, w_prod_nxt;
  logic [DW-1:0]   r_mplier, r_hi;
  logic [CW-1:0]   r_cnt;
  logic            w_mul_last;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_last  = 1'b0;
    w_prod_nxt  = r_prod + (r_mplier[0] ? r_mcand : '0);
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL: begin
        if (flush_i) w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_mul_last  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplicand is pre-shifted each step instead of indexing by count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_is_mul) begin
        r_prod   <= '0;
        r_mcand  <= {{DW{1'b0}}, a_data_i};
        r_mplier <= b_data_i;
        r_cnt    <= '0;
      end
    end else begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                      r_hi <= '0;
    else if (w_accept && !w_is_mul) r_hi <= '0;
    else if (w_mul_last)            r_hi <= w_prod_nxt[2*DW-1:DW];
  end

  assign w_busy    = (r_state == S_MUL);
  assign hi_data_o = r_hi;
`else
  assign w_busy    = 1'b0;
  assign hi_data_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu  <= '0;
      r_zero <= 1'b1;
      r_ovf  <= 1'b0;
      r_ill  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_alu  <= w_res;
        r_zero <= (w_res == '0);
        r_ovf  <= w_ovf;
        r_ill  <= w_ill;
        r_done <= 1'b1;
      end
`ifdef ALU_SEQ_MULT_EN
      else if (w_mul_last) begin
        r_alu  <= w_prod_nxt[DW-1:0];
        r_zero <= (w_prod_nxt[DW-1:0] == '0);
        r_ovf  <= 1'b0;
        r_ill  <= 1'b0;
        r_done <= 1'b1;
      end
`endif
    end
  end

  assign alu_data_o = r_alu;
  assign zero_o     = r_zero;
  assign overflow_o = r_ovf;
  assign illegal_o  = r_ill;
  assign busy_o     = w_busy;
  assign done_o     = r_done;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed + randomized bench for alu_seq_unit against an arithmetic reference model.
module tb_alu_seq_unit;
  localparam int DW = 32;
  localparam logic [3:0] OP_OR = 4'b0010, OP_ADD = 4'b0011, OP_SUB = 4'b0100,
                         OP_LUI = 4'b0101, OP_MULT = 4'b0110;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          reset, start_i, flush_i;
  logic [3:0]    op;
  logic [DW-1:0] a, b, alu, hi;
  logic          zero, ovf, ill, busy, done;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] e_alu = '0, e_hi = '0;
  logic          e_zero = 1'b1, e_ovf = 1'b0, e_ill = 1'b0;

  always #5 clk = ~clk;

  alu_seq_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .flush_i(flush_i),
    .alu_operation_i(op), .a_data_i(a), .b_data_i(b),
    .alu_data_o(alu), .hi_data_o(hi), .zero_o(zero), .overflow_o(ovf),
    .illegal_o(ill), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "/alu"},  alu,  e_alu);
    chk({tag, "/hi"},   hi,   e_hi);
    chk({tag, "/zero"}, zero, e_zero);
    chk({tag, "/ovf"},  ovf,  e_ovf);
    chk({tag, "/ill"},  ill,  e_ill);
  endtask

  // Reference: signed overflow judged by exact 64-bit arithmetic.
  task automatic model(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    e_hi = '0; e_ovf = 1'b0; e_ill = 1'b0;
    case (o)
      OP_ADD: begin e_alu = x + y; s = sx + sy; e_ovf = (s > MAXS) || (s < MINS); end
      OP_SUB: begin e_alu = x - y; s = sx - sy; e_ovf = (s > MAXS) || (s < MINS); end
      OP_OR:  e_alu = x | y;
      OP_LUI: e_alu = {y[15:0], 16'h0000};
      default: begin e_alu = '0; e_ill = 1'b1; end
    endcase
    e_zero = (e_alu == 0);
  endtask

  task automatic step(input logic st, input logic [3:0] o, input logic [DW-1:0] x,
                      input logic [DW-1:0] y, input string tag);
    logic iss;
    iss = st && !flush_i;
    start_i = st; op = o; a = x; b = y;
    @(negedge clk);
    start_i = 1'b0;
    if (iss) model(o, x, y);
    chk({tag, "/done"}, done, iss);
    chk({tag, "/busy"}, busy, 1'b0);
    check_outs(tag);
  endtask

`ifdef ALU_SEQ_MULT_EN
  task automatic run_mul(input logic [DW-1:0] x, input logic [DW-1:0] y, input string tag);
    logic [63:0] p;
    start_i = 1'b1; op = OP_MULT; a = x; b = y;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "/busy0"}, busy, 1'b1);
    for (int k = 1; k < DW; k++) begin
      if (k == 10) begin start_i = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1; end
      @(negedge clk);
      start_i = 1'b0;
      chk({tag, "/busy_k"}, busy, 1'b1);
      chk({tag, "/done_k"}, done, 1'b0);
    end
    @(negedge clk);
    p = 64'(x) * 64'(y);
    e_alu = p[31:0]; e_hi = p[63:32]; e_zero = (e_alu == 0); e_ovf = 1'b0; e_ill = 1'b0;
    chk({tag, "/done"}, done, 1'b1);
    chk({tag, "/busy"}, busy, 1'b0);
    check_outs(tag);
  endtask

  task automatic abort_mul(input logic use_reset, input string tag);
    start_i = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk({tag, "/busy_k"}, busy, 1'b1);
    end
    if (use_reset) reset = 1'b1; else flush_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush_i = 1'b0;
    if (use_reset) begin e_alu = '0; e_hi = '0; e_zero = 1'b1; e_ovf = 1'b0; e_ill = 1'b0; end
    chk({tag, "/busy"}, busy, 1'b0);
    chk({tag, "/done"}, done, 1'b0);
    check_outs(tag);
    for (int k = 0; k < DW + 2; k++) step(1'b0, OP_ADD, '0, '0, {tag, "/quiet"});
  endtask
`endif

  initial begin
    logic [3:0]    ro;
    logic [DW-1:0] ra, rb;
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset/busy", busy, 1'b0);
    chk("reset/done", done, 1'b0);
    check_outs("reset");
    reset = 1'b0;

    step(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    chk("add_ovf/const_alu", alu, 32'h8000_0000);
    chk("add_ovf/const_ovf", ovf, 1'b1);
    step(1'b0, OP_ADD, '0, '0, "add_single_pulse");

    step(1'b1, OP_SUB, 32'd5, 32'd5, "sub_zero");
    chk("sub_zero/const_zero", zero, 1'b1);
    step(1'b1, OP_LUI, 32'd7, 32'h0000_ABCD, "lui");
    chk("lui/const_alu", alu, 32'hABCD_0000);
    step(1'b0, OP_ADD, '0, '0, "lui_hold");

    step(1'b1, 4'b1001, 32'h1234, 32'h5678, "illegal_1001");
    chk("illegal_1001/const_ill", ill, 1'b1);
    step(1'b1, OP_SUB, 32'h8000_0000, 32'h1, "sub_ovf");

    flush_i = 1'b1;
    step(1'b1, OP_OR, 32'hF0, 32'h0F, "flush_idle");
    flush_i = 1'b0;

`ifdef ALU_SEQ_MULT_EN
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    chk("mul_max/const_hi", hi, 32'hFFFF_FFFE);
    step(1'b1, OP_OR, 32'hA0, 32'h05, "b2b_after_mul");
    run_mul(32'd0, 32'h1234, "mul_zero");
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, "mul_rand");
    abort_mul(1'b0, "mul_flush");
    abort_mul(1'b1, "mul_reset");
`else
    step(1'b1, OP_MULT, 32'd3, 32'd4, "mult_disabled");
    chk("mult_disabled/const_ill", ill, 1'b1);
`endif

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: ro = OP_ADD;
        1: ro = OP_SUB;
        2: ro = OP_OR;
        3: ro = OP_LUI;
        4: ro = 4'($urandom);
        default: ro = OP_MULT;
      endcase
`ifdef ALU_SEQ_MULT_EN
      if (ro == OP_MULT) ro = 4'hF;
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step($urandom_range(0, 3) != 0, ro, ra, rb, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
